// File: rtl/seek_controller_if.sv
// Signal bundle between the host register file / step controller and the seek sequencer.
// Handshake: CMD_SEEK/CMD_RECAL are 1-cycle strobes honoured only while BUSY=0; DONE and SC_WRITE are 1-cycle strobes.
interface seek_controller_if;
  logic       CMD_SEEK;
  logic       CMD_RECAL;
  logic [6:0] TARGET;
  logic [7:0] SETTLE_COUNT;
  logic       SETTLE_TICK;
  logic       TRACK0_IN;
  logic       SC_BUSY;
  logic [7:0] SC_CTLBYTE;
  logic       SC_WRITE;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;
  logic [6:0] CUR_TRACK;
  logic       TRACK_VALID;
  logic [2:0] STATE_DBG;

  modport slave (
    input  CMD_SEEK, CMD_RECAL, TARGET, SETTLE_COUNT, SETTLE_TICK, TRACK0_IN, SC_BUSY,
    output SC_CTLBYTE, SC_WRITE, BUSY, DONE, ERROR, CUR_TRACK, TRACK_VALID, STATE_DBG
  );

  modport master (
    output CMD_SEEK, CMD_RECAL, TARGET, SETTLE_COUNT, SETTLE_TICK, TRACK0_IN, SC_BUSY,
    input  SC_CTLBYTE, SC_WRITE, BUSY, DONE, ERROR, CUR_TRACK, TRACK_VALID, STATE_DBG
  );
endinterface

// File: rtl/seek_controller.sv
// Turns absolute seek / recalibrate commands into relative step-controller bursts,
// tracks the head position and enforces head-settle time before DONE.
module seek_controller #(
  parameter int MAX_TRACK   = 83,
  parameter int RECAL_TRIES = 2
) (
  input logic              CLK,
  input logic              RESET_n,
  seek_controller_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_START, WAIT_DONE, EVAL, SETTLE, FINISH
  } state_t;

  state_t     state, state_nx;
  logic       is_recal, dir_q, settle_first, error_q, track_valid_q;
  logic [6:0] target_q, cur_track_q, delta;
  logic [2:0] retry_q;
  logic [7:0] settle_q, settle_next, ctlbyte_q;
  logic       accept_recal, accept_seek, seek_bad, seek_same, seek_dir;
  logic       sc_write, busy, done;

  always_comb begin
    accept_recal = (state == IDLE) && bus.CMD_RECAL;
    accept_seek  = (state == IDLE) && bus.CMD_SEEK && !bus.CMD_RECAL;
    seek_bad     = !track_valid_q || (bus.TARGET > 7'(MAX_TRACK));
    seek_same    = (bus.TARGET == cur_track_q);
    seek_dir     = (bus.TARGET < cur_track_q);
    delta        = seek_dir ? (cur_track_q - bus.TARGET) : (bus.TARGET - cur_track_q);
    // First settle cycle only loads the count, so a tick landing there is ignored.
    settle_next  = settle_first ? bus.SETTLE_COUNT : (settle_q - {7'd0, bus.SETTLE_TICK});

    state_nx = state;
    sc_write = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept_recal)
          state_nx = bus.TRACK0_IN ? SETTLE : ISSUE;
        else if (accept_seek)
          state_nx = (seek_bad || seek_same) ? FINISH : ISSUE;
      end
      ISSUE: begin
        busy     = 1'b1;
        sc_write = 1'b1;
        state_nx = WAIT_START;
      end
      WAIT_START: begin
        busy = 1'b1;
        if (bus.SC_BUSY) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (!bus.SC_BUSY) state_nx = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (!is_recal || bus.TRACK0_IN) state_nx = SETTLE;
        else if (retry_q == 3'd1)       state_nx = FINISH;
        else                            state_nx = ISSUE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_next == 8'd0) state_nx = FINISH;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      is_recal      <= 1'b0;
      dir_q         <= 1'b0;
      target_q      <= 7'd0;
      retry_q       <= 3'd0;
      settle_q      <= 8'd0;
      settle_first  <= 1'b0;
      ctlbyte_q     <= 8'd0;
      error_q       <= 1'b0;
      cur_track_q   <= 7'd0;
      track_valid_q <= 1'b0;
    end else begin
      settle_first <= (state_nx == SETTLE) && (state != SETTLE);
      if (state == SETTLE) settle_q <= settle_next;
      case (state)
        IDLE: begin
          if (accept_recal) begin
            is_recal <= 1'b1;
            error_q  <= 1'b0;
            if (bus.TRACK0_IN) begin
              cur_track_q   <= 7'd0;
              track_valid_q <= 1'b1;
            end else begin
              track_valid_q <= 1'b0;
              retry_q       <= 3'(RECAL_TRIES);
              ctlbyte_q     <= 8'hFF;
            end
          end else if (accept_seek) begin
            is_recal <= 1'b0;
            target_q <= bus.TARGET;
            dir_q    <= seek_dir;
            error_q  <= seek_bad;
            if (!seek_bad && !seek_same) ctlbyte_q <= {seek_dir, delta - 7'd1};
          end
        end
        EVAL: begin
          if (is_recal) begin
            if (bus.TRACK0_IN) begin
              cur_track_q   <= 7'd0;
              track_valid_q <= 1'b1;
            end else begin
              retry_q <= retry_q - 3'd1;
              if (retry_q == 3'd1) begin
                error_q       <= 1'b1;
                track_valid_q <= 1'b0;
              end
            end
          end else if (dir_q && bus.TRACK0_IN && (target_q != 7'd0)) begin
            // Hit the track-0 stop before the expected track: position was wrong.
            cur_track_q <= 7'd0;
            error_q     <= 1'b1;
          end else begin
            cur_track_q <= target_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.SC_CTLBYTE  = ctlbyte_q;
  assign bus.SC_WRITE    = sc_write;
  assign bus.BUSY        = busy;
  assign bus.DONE        = done;
  assign bus.ERROR       = error_q;
  assign bus.CUR_TRACK   = cur_track_q;
  assign bus.TRACK_VALID = track_valid_q;
  assign bus.STATE_DBG   = state;
endmodule

// File: tb/tb_seek_controller.sv
// Bench for seek_controller: physical head/step-controller model, random settle ticks,
// transaction-level result model and a per-cycle compare process.
module tb_seek_controller;
  localparam int MAX_TRACK   = 83;
  localparam int RECAL_TRIES = 2;
  localparam int TICK_LOG    = 100000;
  localparam int K_IMM = 0, K_ACC = 1, K_MOT = 2, K_FAIL = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seek_controller_if bus();
  seek_controller #(.MAX_TRACK(MAX_TRACK), .RECAL_TRIES(RECAL_TRIES)) dut (
    .CLK(clk), .RESET_n(rst_n), .bus(bus)
  );

  // ---------------- bench state ----------------
  int   total = 0, bad = 0;
  logic [7:0] exp_q[$];
  int   m_cur = 0, m_valid = 0, m_err = 0;
  logic [7:0] m_ctl = 8'h00;
  int   p_cur, p_valid, p_err, kind, settle_n, acc_cyc;
  bit   cmd_active = 0, in_reset = 1;
  int   done_cnt = 0, write_cnt = 0, last_fall = 0;
  logic [7:0] last_write = 8'h00;
  int   head_pos;
  bit   t0_broken = 0, t0_force = 0;
  bit   tick_at [TICK_LOG];

  assign bus.TRACK0_IN = ((head_pos == 0) && !t0_broken) || t0_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DONE cycle from the command's state sequence: settle starts two cycles after the
  // step controller goes idle (or the cycle after a recal accepted on track 0).
  function automatic int exp_done_cycle();
    int e, n;
    if (kind == K_IMM)  return acc_cyc + 1;
    if (kind == K_FAIL) return last_fall + 2;
    e = (kind == K_ACC) ? acc_cyc + 1 : last_fall + 2;
    if (settle_n == 0) return e + 1;
    n = 0;
    for (int t = e + 1; t < cyc && t < TICK_LOG; t++) begin
      if (tick_at[t]) n++;
      if (n == settle_n) return t + 1;
    end
    return -1;
  endfunction

  // ---------------- settle timebase ----------------
  initial begin
    bus.SETTLE_TICK = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.SETTLE_TICK = ($urandom_range(0, 3) == 0);
      if (cyc < TICK_LOG) tick_at[cyc] = bus.SETTLE_TICK;
    end
  end

  // ---------------- step controller + head mechanics ----------------
  initial begin
    logic [7:0] c;
    int n;
    head_pos = 40;
    bus.SC_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.SC_WRITE === 1'b1) begin
        c = bus.SC_CTLBYTE;
        n = int'(c[6:0]) + 1;
        repeat (2) @(posedge clk);
        #1 bus.SC_BUSY = 1'b1;
        for (int i = 0; i < n; i++) begin
          repeat (2) @(posedge clk);
          #1;
          if (c[7]) begin
            if (head_pos > 0) head_pos--;
          end else if (head_pos < 90) head_pos++;
        end
        @(posedge clk);
        #1 bus.SC_BUSY = 1'b0;
        last_fall = cyc;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [7:0] exp_c;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (bus.SC_WRITE === 1'b1) begin
          write_cnt++;
          last_write = bus.SC_CTLBYTE;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: got ctl=%02h required no write (cycle %0d)", bus.SC_CTLBYTE, cyc);
          end else begin
            exp_c = exp_q.pop_front();
            check("sc_ctlbyte", bus.SC_CTLBYTE, exp_c);
            m_ctl = exp_c;
          end
        end
        if (bus.DONE !== 1'b0) begin
          if (!cmd_active) begin
            total++; bad++;
            $display("FAIL unexpected_done: got DONE=%b required 0 (cycle %0d)", bus.DONE, cyc);
          end else begin
            check("done_error", bus.ERROR, p_err);
            check("done_cur_track", bus.CUR_TRACK, p_cur);
            check("done_track_valid", bus.TRACK_VALID, p_valid);
            check("done_cycle", cyc, exp_done_cycle());
            m_err = p_err; m_cur = p_cur; m_valid = p_valid;
            done_cnt++;
          end
        end
        if (cmd_active && cyc > acc_cyc)
          check("busy_active", bus.BUSY, (bus.DONE === 1'b1) ? 0 : 1);
        if (!cmd_active) begin
          check("idle_busy", bus.BUSY, 0);
          check("idle_error", bus.ERROR, m_err);
          check("idle_cur_track", bus.CUR_TRACK, m_cur);
          check("idle_track_valid", bus.TRACK_VALID, m_valid);
          check("idle_ctlbyte", bus.SC_CTLBYTE, m_ctl);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    in_reset = 1; cmd_active = 0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_sc_write", bus.SC_WRITE, 0);
    check("rst_ctlbyte", bus.SC_CTLBYTE, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_error", bus.ERROR, 0);
    check("rst_cur_track", bus.CUR_TRACK, 0);
    check("rst_track_valid", bus.TRACK_VALID, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_q.delete();
    m_cur = 0; m_valid = 0; m_err = 0; m_ctl = 8'h00;
    in_reset = 0;
  endtask

  task automatic strobe(input bit s, input bit r);
    acc_cyc = cyc; cmd_active = 1;
    bus.CMD_SEEK = s; bus.CMD_RECAL = r;
    @(posedge clk); #2;
    bus.CMD_SEEK = 1'b0; bus.CMD_RECAL = 1'b0;
  endtask

  task automatic wait_done();
    int start = done_cnt;
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != start) begin got = 1; break; end
      @(posedge clk); #2;
    end
    check("done_seen", got, 1);
    check("writes_left", exp_q.size(), 0);
    exp_q.delete();
    cmd_active = 0;
  endtask

  task automatic wait_sc_busy(input bit lvl, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.SC_BUSY == lvl) begin seen = 1; break; end
      @(posedge clk); #2;
    end
    check("sc_busy_wait", seen, 1);
  endtask

  task automatic run_seek(input int tgt, input int ns, input bit poke, input bit abort);
    int d, ha;
    bit t0_after;
    bus.SETTLE_COUNT = 8'(ns); settle_n = ns;
    bus.TARGET = 7'(tgt);
    p_valid = m_valid; p_cur = m_cur; p_err = 0; kind = K_IMM;
    if (m_valid == 0 || tgt > MAX_TRACK) p_err = 1;
    else if (tgt != m_cur) begin
      d  = tgt - m_cur;
      ha = head_pos + d;
      if (ha < 0)  ha = 0;
      if (ha > 90) ha = 90;
      t0_after = ((ha == 0) && !t0_broken) || t0_force;
      exp_q.push_back({d < 0, 7'(((d < 0) ? -d : d) - 1)});
      if (d < 0 && t0_after && tgt != 0) begin p_err = 1; p_cur = 0; end
      else p_cur = tgt;
      kind = K_MOT;
    end
    strobe(1'b1, 1'b0);
    if (abort) begin
      wait_sc_busy(1'b1, 50);
      repeat (3) begin @(posedge clk); #2; end
      do_reset();
      wait_sc_busy(1'b0, 400);
      repeat (3) begin @(posedge clk); #2; end
      return;
    end
    if (poke) begin
      wait_sc_busy(1'b1, 50);
      bus.CMD_SEEK = 1'b1; bus.CMD_RECAL = 1'b1;
      @(posedge clk); #2;
      bus.CMD_SEEK = 1'b0; bus.CMD_RECAL = 1'b0;
    end
    wait_done();
  endtask

  task automatic run_recal(input int ns, input bit both);
    bus.SETTLE_COUNT = 8'(ns); settle_n = ns;
    if (((head_pos == 0) && !t0_broken) || t0_force) begin
      p_cur = 0; p_valid = 1; p_err = 0; kind = K_ACC;
    end else if (!t0_broken) begin
      for (int i = 0; i < (head_pos + 127) / 128; i++) exp_q.push_back(8'hFF);
      p_cur = 0; p_valid = 1; p_err = 0; kind = K_MOT;
    end else begin
      for (int i = 0; i < RECAL_TRIES; i++) exp_q.push_back(8'hFF);
      p_cur = m_cur; p_valid = 0; p_err = 1; kind = K_FAIL;
    end
    strobe(both, 1'b1);
    wait_done();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int wc, r;
    rst_n = 1'b0;
    bus.CMD_SEEK = 1'b0; bus.CMD_RECAL = 1'b0;
    bus.TARGET = 7'd0; bus.SETTLE_COUNT = 8'd0;
    @(posedge clk); #2;
    do_reset();

    run_seek(5, 0, 0, 0);
    check("lit_seek_novalid_err", bus.ERROR, 1);
    check("lit_seek_novalid_cur", bus.CUR_TRACK, 0);

    wc = write_cnt;
    run_recal(3, 0);
    check("lit_recal_writes", write_cnt - wc, 1);
    check("lit_recal_ctl", last_write, 8'hFF);
    check("lit_recal_valid", bus.TRACK_VALID, 1);

    run_seek(10, 2, 0, 0);
    check("lit_ctl_in10", last_write, 8'h09);
    check("lit_cur_10", bus.CUR_TRACK, 10);
    run_seek(4, 1, 0, 0);
    check("lit_ctl_out6", last_write, 8'h85);
    check("lit_cur_4", bus.CUR_TRACK, 4);

    wc = write_cnt;
    run_seek(84, 1, 0, 0);
    check("lit_err_84", bus.ERROR, 1);
    run_seek(4, 1, 0, 0);
    check("lit_err_same", bus.ERROR, 0);
    check("lit_no_writes", write_cnt - wc, 0);

    wc = write_cnt;
    t0_broken = 1;
    run_recal(2, 0);
    check("lit_recal_fail_writes", write_cnt - wc, RECAL_TRIES);
    check("lit_recal_fail_err", bus.ERROR, 1);
    check("lit_recal_fail_valid", bus.TRACK_VALID, 0);
    t0_broken = 0;
    run_recal(0, 0);

    run_seek(10, 1, 0, 0);
    t0_force = 1;
    run_seek(4, 1, 0, 0);
    check("lit_slip_err", bus.ERROR, 1);
    check("lit_slip_cur", bus.CUR_TRACK, 0);
    t0_force = 0;
    run_recal(1, 0);

    run_seek(60, 0, 0, 1);
    wc = write_cnt;
    run_recal(2, 1);
    check("lit_pair_recal_writes", write_cnt - wc, 1);
    check("lit_pair_recal_valid", bus.TRACK_VALID, 1);
    wc = write_cnt;
    run_seek(30, 1, 1, 0);
    check("lit_poke_writes", write_cnt - wc, 1);
    check("lit_poke_cur", bus.CUR_TRACK, 30);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) run_recal($urandom_range(0, 3), 1'b0);
      else if (r == 1) run_seek(m_cur, $urandom_range(0, 3), 0, 0);
      else run_seek($urandom_range(0, 90), $urandom_range(0, 3), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
